// File: rtl/rpn_stack_core.sv
// Purpose: RPN evaluation engine; WIDTH-bit, DEPTH-entry operand stack with binary ALU.
// Latency: PUSH/POP/CLEAR take effect on the accept edge; OPERATE result is visible 2 cycles after accept.
// Backpressure: cmd_ready depends on state only; it is low during FETCH/EXEC and high in IDLE/ERROR.
// Ports: clk/rst_n (async active-low); cmd_valid/cmd_ready/cmd_op/cmd_alu/cmd_data command port;
//        top/count/carry registered stack view; err_overflow/err_underflow sticky until CLEAR or reset.
module rpn_stack_core #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [2:0]       cmd_alu,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [WIDTH-1:0] top,
  output logic [CW-1:0]    count,
  output logic             carry,
  output logic             err_overflow,
  output logic             err_underflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;
  localparam logic [1:0] S_ERROR = 2'd3;

  localparam logic [1:0] OP_PUSH    = 2'b00;
  localparam logic [1:0] OP_OPERATE = 2'b01;
  localparam logic [1:0] OP_POP     = 2'b10;
  localparam logic [1:0] OP_CLEAR   = 2'b11;

  logic [1:0]       state;
  logic [2:0]       alu_sel;
  logic [WIDTH-1:0] opa;   // deeper entry
  logic [WIDTH-1:0] opb;   // top entry
  logic [WIDTH-1:0] mem [DEPTH];

  logic             full;
  logic [AW-1:0]    idx_m1;
  logic [AW-1:0]    idx_m2;
  logic [AW-1:0]    idx_push;

  logic             mem_we;
  logic [AW-1:0]    mem_wa;
  logic [WIDTH-1:0] mem_wd;

  logic [WIDTH-1:0] alu_r;
  logic             alu_c;

  assign cmd_ready = (state == S_IDLE) || (state == S_ERROR);
  assign full      = (count == CW'(DEPTH));
  // Indices are only used when count guarantees they are in range.
  assign idx_m1    = AW'(count - CW'(1));
  assign idx_m2    = AW'(count - CW'(2));
  assign idx_push  = AW'(count);

  // ALU on the operands captured during FETCH.
  always_comb begin
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod;
    sum   = {1'b0, opa} + {1'b0, opb};
    prod  = {{WIDTH{1'b0}}, opa} * {{WIDTH{1'b0}}, opb};
    alu_r = '0;
    alu_c = 1'b0;
    case (alu_sel)
      3'b000: begin alu_r = sum[WIDTH-1:0]; alu_c = sum[WIDTH]; end
      3'b001: begin alu_r = opa - opb; alu_c = (opa < opb); end
      3'b010: begin alu_r = prod[WIDTH-1:0]; alu_c = |prod[2*WIDTH-1:WIDTH]; end
      3'b011: alu_r = opa & opb;
      3'b100: alu_r = opa | opb;
      3'b101: alu_r = opa ^ opb;
      3'b110: alu_r = (opa < opb) ? opa : opb;
      default: alu_r = (opa > opb) ? opa : opb;
    endcase
  end

  // Single write port shared by PUSH (IDLE) and write-back (EXEC); never both in one cycle.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = '0;
    mem_wd = '0;
    if (state == S_IDLE && cmd_valid && cmd_op == OP_PUSH && !full) begin
      mem_we = 1'b1;
      mem_wa = idx_push;
      mem_wd = cmd_data;
    end else if (state == S_EXEC) begin
      mem_we = 1'b1;
      mem_wa = idx_m2;
      mem_wd = alu_r;
    end
  end

  // Entry storage is not reset; count alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      count         <= '0;
      top           <= '0;
      carry         <= 1'b0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
      alu_sel       <= '0;
      opa           <= '0;
      opb           <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            case (cmd_op)
              OP_PUSH: begin
                if (full) begin
                  err_overflow <= 1'b1;
                  state        <= S_ERROR;
                end else begin
                  count <= count + CW'(1);
                  top   <= cmd_data;
                end
              end
              OP_OPERATE: begin
                if (count < CW'(2)) begin
                  err_underflow <= 1'b1;
                  state         <= S_ERROR;
                end else begin
                  alu_sel <= cmd_alu;
                  state   <= S_FETCH;
                end
              end
              OP_POP: begin
                if (count == '0) begin
                  err_underflow <= 1'b1;
                  state         <= S_ERROR;
                end else begin
                  count <= count - CW'(1);
                  // The entry below the popped one becomes the new top.
                  top   <= (count >= CW'(2)) ? mem[idx_m2] : '0;
                end
              end
              default: begin
                count         <= '0;
                top           <= '0;
                carry         <= 1'b0;
                err_overflow  <= 1'b0;
                err_underflow <= 1'b0;
              end
            endcase
          end
        end
        S_FETCH: begin
          opb   <= mem[idx_m1];
          opa   <= mem[idx_m2];
          state <= S_EXEC;
        end
        S_EXEC: begin
          top   <= alu_r;
          count <= count - CW'(1);
          carry <= alu_c;
          state <= S_IDLE;
        end
        default: begin
          // ERROR: everything except CLEAR is accepted and discarded.
          if (cmd_valid && cmd_op == OP_CLEAR) begin
            count         <= '0;
            top           <= '0;
            carry         <= 1'b0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
            state         <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rpn_stack_core.sv
// Purpose: self-checking bench for rpn_stack_core (WIDTH=8, DEPTH=4) with a stack-level reference model.
// Latency: model applies OPERATE results two edges after acceptance and expects cmd_ready low meanwhile.
// Backpressure: commands issued while the DUT is busy are expected to be dropped by both sides.
module tb_rpn_stack_core;

  localparam int W    = 8;
  localparam int D    = 4;
  localparam int CW   = $clog2(D + 1);
  localparam int MASK = (1 << W) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [2:0]    cmd_alu;
  logic [W-1:0]  cmd_data;
  logic [W-1:0]  top;
  logic [CW-1:0] count;
  logic          carry;
  logic          err_overflow;
  logic          err_underflow;

  always #5 clk = ~clk;

  rpn_stack_core #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_alu(cmd_alu), .cmd_data(cmd_data),
    .top(top), .count(count), .carry(carry),
    .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // ---------------- reference model ----------------
  int stk[$];
  int busy = 0;
  int m_alu = 0;
  bit m_err = 0, m_ovf = 0, m_unf = 0, m_carry = 0;

  function automatic int alu_f(input int a, input int b, input int op, output bit c);
    int t;
    c = 1'b0;
    case (op)
      0: begin t = a + b; c = (t > MASK); return t & MASK; end
      1: begin c = (a < b); return (a - b) & MASK; end
      2: begin t = a * b; c = ((t >> W) != 0); return t & MASK; end
      3: return a & b;
      4: return a | b;
      5: return a ^ b;
      6: return (a < b) ? a : b;
      default: return (a > b) ? a : b;
    endcase
  endfunction

  initial begin : model
    int a, b, r;
    bit c;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        stk.delete(); busy = 0; m_err = 0; m_ovf = 0; m_unf = 0; m_carry = 0;
      end else if (busy > 0) begin
        busy--;
        if (busy == 0) begin
          b = stk.pop_back();
          a = stk.pop_back();
          r = alu_f(a, b, m_alu, c);
          stk.push_back(r);
          m_carry = c;
        end
      end else if (cmd_valid) begin
        if (cmd_op == 2'b11) begin
          stk.delete(); m_err = 0; m_ovf = 0; m_unf = 0; m_carry = 0;
        end else if (!m_err) begin
          case (cmd_op)
            2'b00: if (stk.size() < D) stk.push_back(int'(cmd_data));
                   else begin m_ovf = 1; m_err = 1; end
            2'b01: if (stk.size() >= 2) begin busy = 2; m_alu = int'(cmd_alu); end
                   else begin m_unf = 1; m_err = 1; end
            default: if (stk.size() >= 1) void'(stk.pop_back());
                     else begin m_unf = 1; m_err = 1; end
          endcase
        end
      end
    end
  end

  // ---------------- per-cycle comparison ----------------
  initial begin : compare
    int exp_top;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        exp_top = (stk.size() == 0) ? 0 : stk[stk.size()-1];
        chk("cyc_count", count, stk.size());
        chk("cyc_top", top, exp_top);
        chk("cyc_carry", carry, m_carry);
        chk("cyc_ovf", err_overflow, m_ovf);
        chk("cyc_unf", err_underflow, m_unf);
        chk("cyc_ready", cmd_ready, busy == 0);
      end
    end
  end

  // ---------------- stimulus helpers (called at a falling edge) ----------------
  task automatic issue(input logic [1:0] op, input logic [2:0] alu, input logic [W-1:0] d);
    cmd_valid = 1'b1; cmd_op = op; cmd_alu = alu; cmd_data = d;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic push(input logic [W-1:0] d); issue(2'b00, 3'b000, d); endtask
  task automatic pop();                       issue(2'b10, 3'b000, '0); endtask
  task automatic clear();                     issue(2'b11, 3'b000, '0); endtask
  task automatic operate(input logic [2:0] alu);
    issue(2'b01, alu, '0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 8) begin @(negedge clk); n++; end
    if (!cmd_ready) chk("ready_timeout", cmd_ready, 1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int r;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_alu = '0; cmd_data = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_count", count, 0);
    chk("rst_top", top, 0);
    chk("rst_carry", carry, 0);
    chk("rst_ovf", err_overflow, 0);
    chk("rst_unf", err_underflow, 0);
    chk("rst_ready", cmd_ready, 1);

    // 5 + 3 with exact latency
    push(5); push(3);
    issue(2'b01, 3'b000, '0);
    chk("add_c1_ready", cmd_ready, 0); chk("add_c1_top", top, 3);
    @(negedge clk);
    chk("add_c2_ready", cmd_ready, 0); chk("add_c2_count", count, 2);
    @(negedge clk);
    chk("add_top", top, 8); chk("add_count", count, 1);
    chk("add_carry", carry, 0); chk("add_ready", cmd_ready, 1);

    // width wrap cases
    clear();
    push(200); push(100); operate(3'b000);
    chk("add_wrap_top", top, 44); chk("add_wrap_carry", carry, 1);
    push(3); push(5); operate(3'b001);
    chk("sub_top", top, 254); chk("sub_borrow", carry, 1); chk("sub_count", count, 2);
    push(16); push(16); operate(3'b010);
    chk("mul_top", top, 0); chk("mul_carry", carry, 1); chk("mul_count", count, 3);
    pop();
    chk("pop_top", top, 254); chk("pop_count", count, 2);

    // overflow and ERROR behaviour
    clear();
    push(1); push(2); push(3); push(4); push(9);
    chk("ovf_flag", err_overflow, 1); chk("ovf_count", count, 4); chk("ovf_top", top, 4);
    push(7);
    chk("err_push_count", count, 4); chk("err_push_top", top, 4); chk("err_ready", cmd_ready, 1);
    clear();
    chk("clr_count", count, 0); chk("clr_ovf", err_overflow, 0);

    // underflow
    issue(2'b01, 3'b001, '0);
    chk("unf_operate", err_underflow, 1);
    clear();
    chk("unf_cleared", err_underflow, 0);
    push(6); pop();
    chk("pop_empty_count", count, 0); chk("pop_empty_top", top, 0);
    pop();
    chk("unf_pop", err_underflow, 1);
    clear();

    // back-to-back pushes, max then min
    push(2); push(9); push(4);
    issue(2'b01, 3'b111, '0);
    chk("max_c1_ready", cmd_ready, 0);
    @(negedge clk); chk("max_c2_ready", cmd_ready, 0);
    @(negedge clk); chk("max_ready", cmd_ready, 1); chk("max_top", top, 9);
    operate(3'b110);
    chk("min_top", top, 2); chk("min_count", count, 1);

    // reset during FETCH aborts the operation
    clear();
    push(16); push(16); operate(3'b010);
    chk("pre_rst_carry", carry, 1);
    push(10); push(20);
    issue(2'b01, 3'b000, '0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count", count, 0); chk("arst_top", top, 0); chk("arst_carry", carry, 0);
    @(negedge clk);
    rst_n = 1'b1;
    push(1);
    chk("post_rst_count", count, 1); chk("post_rst_top", top, 1);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 4) != 0) wait_ready();
      r = $urandom_range(0, 99);
      if (r < 45)      issue(2'b00, 3'($urandom_range(0, 7)), W'($urandom));
      else if (r < 75) issue(2'b01, 3'($urandom_range(0, 7)), W'($urandom));
      else if (r < 95) issue(2'b10, 3'($urandom_range(0, 7)), W'($urandom));
      else             issue(2'b11, 3'($urandom_range(0, 7)), W'($urandom));
      if ($urandom_range(0, 2) == 0) @(negedge clk);
    end
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
